// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the dmem_responder slice.
//   size_e   : access size encoding carried on req_size (2'b11 is reserved)
//   state_e  : responder FSM states
//   WORD_BYTES : byte lanes per array word
//   is_misaligned() : alignment rule for a given size and byte offset
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    localparam int WORD_BYTES = 4;

    // Halves need an even offset, words need offset 0; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_H:    return lo[0];
            SZ_W:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering between the request port and a 32-bit word.
//   Store path: i_size, i_lo, i_wdata -> o_be (byte enables), o_wword
//               (store data replicated across all lanes).
//   Load path : i_size, i_lo, i_unsigned, i_rword -> o_rdata (selected lane,
//               sign- or zero-extended to 32 bits).
// Ports:
//   i_size     [1:0]  access size (size_e; 2'b11 handled as word)
//   i_lo       [1:0]  byte offset within the word (already aligned by caller)
//   i_wdata    [31:0] right-aligned store data
//   i_unsigned        1 = zero-extend loads, 0 = sign-extend
//   i_rword    [31:0] word read from the array
//   o_be       [3:0]  byte write enables
//   o_wword    [31:0] lane-replicated write word
//   o_rdata    [31:0] extended load result
// -----------------------------------------------------------------------------
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]            i_size,
    input  logic [1:0]            i_lo,
    input  logic [31:0]           i_wdata,
    input  logic                  i_unsigned,
    input  logic [31:0]           i_rword,
    output logic [WORD_BYTES-1:0] o_be,
    output logic [31:0]           o_wword,
    output logic [31:0]           o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select: byte by the full offset, half by offset bit 1.
    assign w_byte = 8'(i_rword >> {i_lo, 3'b000});
    assign w_half = 16'(i_rword >> {i_lo[1], 4'b0000});

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and a latch is inferred.
    always_comb begin
        o_be    = 4'b1111;
        o_wword = i_wdata;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_lo;
                o_wword = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_be    = i_lo[1] ? 4'b1100 : 4'b0011;
                o_wword = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wword = i_wdata;
            end
        endcase
    end

    always_comb begin
        o_rdata = i_rword;
        case (i_size)
            SZ_B:    o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_rdata = i_rword;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the load/store port. Accepts one request at a
// time on a valid/ready channel, performs a byte/half/word access on an
// internal word array and returns the result LATENCY cycles after acceptance
// on a valid/ready response channel.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of 2, >= 2)
//   LATENCY      accept-to-rsp_valid cycles, 1..15
// Build option:
//   DMEM_ERR_EN  defined  : misaligned, out-of-range and reserved-size requests
//                           are flagged on rsp_err and never write.
//                undefined: rsp_err is 0; addresses are aligned down, size 11
//                           acts as word, and word indices wrap.
// Ports:
//   clk, srst (async, active-low)
//   req_valid/req_ready, req_we, req_addr[31:0], req_size[1:0],
//   req_unsigned, req_wdata[31:0]            request channel
//   rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err   response channel
// -----------------------------------------------------------------------------
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    // ---- current request fields ---------------------------------------------
    // With LATENCY = 1 the array access happens on the accepting edge itself,
    // so in IDLE the port fields are used directly; otherwise the latched copy.
    logic        w_sel_in;
    logic        w_cur_we;
    logic [31:0] w_cur_addr;
    logic [1:0]  w_cur_size;
    logic        w_cur_unsigned;
    logic [31:0] w_cur_wdata;

    assign w_sel_in       = (r_state == IDLE);
    assign w_cur_we       = w_sel_in ? req_we       : r_we;
    assign w_cur_addr     = w_sel_in ? req_addr     : r_addr;
    assign w_cur_size     = w_sel_in ? req_size     : r_size;
    assign w_cur_unsigned = w_sel_in ? req_unsigned : r_unsigned;
    assign w_cur_wdata    = w_sel_in ? req_wdata    : r_wdata;

    // ---- error detection / address normalisation ----------------------------
    logic             w_err;
    logic [1:0]       w_eff_size;
    logic [1:0]       w_eff_lo;
    logic [IDX_W-1:0] w_idx;

    assign w_idx = w_cur_addr[2 +: IDX_W];

`ifdef DMEM_ERR_EN
    assign w_err = (w_cur_size == 2'b11)
                || is_misaligned(w_cur_size, w_cur_addr[1:0])
                || (w_cur_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_eff_size = w_cur_size;
    assign w_eff_lo   = w_cur_addr[1:0];
`else
    logic w_unused_addr;

    assign w_err = 1'b0;

    // Misaligned offsets are forced down to the access boundary; index bits
    // above the array depth are dropped, which wraps the address.
    always_comb begin
        w_eff_size = (w_cur_size == 2'b11) ? SZ_W : w_cur_size;
        w_eff_lo   = w_cur_addr[1:0];
        case (w_eff_size)
            SZ_H:    w_eff_lo[0] = 1'b0;
            SZ_W:    w_eff_lo    = 2'b00;
            default: w_eff_lo    = w_cur_addr[1:0];
        endcase
    end

    assign w_unused_addr = ^w_cur_addr[31:2+IDX_W];
`endif

    // ---- lane steering ------------------------------------------------------
    logic [WORD_BYTES-1:0] w_be;
    logic [31:0]           w_wword;
    logic [31:0]           w_rword;
    logic [31:0]           w_align_rdata;
    logic [31:0]           w_load_rdata;

    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size     (w_eff_size),
        .i_lo       (w_eff_lo),
        .i_wdata    (w_cur_wdata),
        .i_unsigned (w_cur_unsigned),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_align_rdata)
    );

    // Stores and erroring requests report zero data.
    assign w_load_rdata = (w_cur_we || w_err) ? 32'h0 : w_align_rdata;

    // The edge that enters RESP both commits a store and captures load data.
    logic w_enter_resp;
    logic w_mem_we;

    assign w_enter_resp = ((r_state == IDLE) && req_valid && (LATENCY == 1))
                       || ((r_state == WAIT) && (r_cnt == 4'd1));
    assign w_mem_we     = w_enter_resp && w_cur_we && !w_err;

    // ---- storage array ------------------------------------------------------
    // NOTE: the array is deliberately left out of reset so it maps onto plain
    // RAM; a reset that drops a pending request cannot reach this write because
    // the FSM has already left WAIT before the next edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

    // ---- control FSM with registered outputs --------------------------------
    // NOTE: all sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge srst) begin
        if (!srst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'h0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_size      <= req_size;
                        r_unsigned  <= req_unsigned;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_load_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_load_rdata;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_req_ready <= 1'b1;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
`ifdef DMEM_ERR_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
    logic w_unused_err;
    assign w_unused_err = r_rsp_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed plus randomized checks of dmem_responder against a byte-addressed
// reference memory kept in the bench. Expectations follow DMEM_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        srst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk          (clk),
        .srst         (srst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference memory, one entry per byte address, little-endian.
    logic [7:0] mm [DEPTH*4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour from the access rules: n bytes at the byte address.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [1:0] size, input logic uns,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic er);
        int unsigned n;
        logic [31:0] a;
        logic [31:0] v;
        n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        er = 1'b0;
        rd = 32'h0;
`ifdef DMEM_ERR_EN
        if (size == 2'b11 || (addr % n) != 0 || (addr / 4) >= DEPTH) er = 1'b1;
        a = addr;
`else
        a = (addr - (addr % n)) % (DEPTH * 4);
`endif
        if (er) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) mm[a + i] = wdata[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(n); i++) v = v | (32'(mm[a + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            rd = v;
        end
    endfunction

    // One full request/response; checks latency, data and error vs the model.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input int stall, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;
        model(we, addr, size, uns, wdata, exp_rd, exp_er);
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 50);
        check({tag, " latency"}, 32'(cyc), 32'(LAT));
        repeat (stall) @(negedge clk);
        check({tag, " rdata"}, rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(rsp_err), 32'(exp_er));
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          cyc;

        srst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);

        // Give words 0..15 known contents.
        for (int w = 0; w < 16; w++) xact("init", 1'b1, 32'(4 * w), 2'b10, 1'b0, $urandom, 0, rd, er);

        // Word store/load round trip and sub-word loads.
        xact("st_w 0x10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, 0, rd, er);
        check("st_w 0x10 err0", 32'(er), 32'd0);
        xact("ld_w 0x10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w 0x10 value", rd, 32'hDEADBEEF);
        xact("ld_b 0x13 s", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, 0, rd, er);
        check("ld_b 0x13 s value", rd, 32'hFFFFFFDE);
        xact("ld_b 0x13 u", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, 0, rd, er);
        check("ld_b 0x13 u value", rd, 32'h000000DE);
        xact("ld_h 0x10 s", 1'b0, 32'h10, 2'b01, 1'b0, 32'h0, 0, rd, er);
        check("ld_h 0x10 s value", rd, 32'hFFFFBEEF);

        // Byte-enable store: only lane 1 changes.
        xact("st_b 0x11", 1'b1, 32'h11, 2'b00, 1'b0, 32'hAAAAAA55, 0, rd, er);
        xact("ld_w after st_b", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w after st_b value", rd, 32'hDEAD55EF);

        // Backpressure: response held, new requests (a store) not accepted.
        model(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_unsigned = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 50);
        check("bp latency", 32'(cyc), 32'(LAT));
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10; req_wdata = 32'hFFFFFFFF;
            @(negedge clk);
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_rdata", rsp_rdata, exp_rd);
            check("bp rsp_err", 32'(rsp_err), 32'(exp_er));
            check("bp req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        xact("ld_w after bp", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w after bp value", rd, 32'hDEAD55EF);

        // Error handling (or alignment/wrap when the checker is not built).
        xact("st_w 0x12", 1'b1, 32'h12, 2'b10, 1'b0, 32'hCAFEF00D, 0, rd, er);
`ifdef DMEM_ERR_EN
        check("st_w 0x12 err", 32'(er), 32'd1);
        xact("ld_w 0x10 after bad st", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w 0x10 unchanged", rd, 32'hDEAD55EF);
        xact("ld_w oor", 1'b0, 32'(DEPTH * 4), 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w oor err", 32'(er), 32'd1);
        check("ld_w oor rdata", rd, 32'h0);
        xact("ld size11", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 0, rd, er);
        check("ld size11 err", 32'(er), 32'd1);
`else
        check("st_w 0x12 err", 32'(er), 32'd0);
        xact("ld_w 0x10 after aligned st", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w 0x10 aligned value", rd, 32'hCAFEF00D);
        xact("ld_w wrap", 1'b0, 32'(DEPTH * 4) + 32'h10, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w wrap value", rd, 32'hCAFEF00D);
        xact("ld size11", 1'b0, 32'h12, 2'b11, 1'b0, 32'h0, 0, rd, er);
        check("ld size11 value", rd, 32'hCAFEF00D);
`endif

        // Reset during WAIT of a store: dropped, no write.
        model(1'b0, 32'h20, 2'b10, 1'b0, 32'h0, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        srst = 1'b0;
        #1;
        check("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mid req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        srst = 1'b1;
        xact("ld_w 0x20 after rst", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, 0, rd, er);
        check("ld_w 0x20 prior content", rd, exp_rd);
        check("ld_w 0x20 not new data", 32'(rd == 32'h12345678), 32'd0);

        // Randomized traffic over the initialised region (and its wrapped alias).
        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH * 4);
            xact("rand", 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom,
                 int'($urandom_range(0, 2)), rd, er);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
